spi_master_tx: RTL

- SPI master transmitter that drives the far end of the team's SPI slave receiver.
- Accepts parallel words over a valid/ready handshake and serialises each word as one chip-select frame on SPI_TX / SPI_CLK / SPI_CS.
- Bus mode: SPI mode 0. SPI_CLK idles low; data changes while SPI_CLK is low; the slave samples on the SPI_CLK rising edge. LSB first by default.
- Sits between the control logic in the system-clock domain and the off-chip or on-chip SPI link.

---
 rtl/spi_master_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: accepts a parallel word over valid/ready and
// shifts it out as one chip-select frame on SPI_TX/SPI_CLK/SPI_CS.
module spi_master_tx #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CS_GAP     = 2,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  busy,
    output logic                  SPI_TX,
    output logic                  SPI_CLK,
    output logic                  SPI_CS
);

    localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] ordered_c;
    logic                  phase_end_c;

    // Word reordered so the first bit on the wire is always at index 0
    always_comb begin
        ordered_c = tx_data;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                ordered_c[i] = tx_data[int'(DATA_WIDTH) - 1 - i];
            end
        end
    end

    assign phase_end_c = (cnt == DIV_LAST);

    // shreg holds only the bits not yet driven; SPI_TX carries the current bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
            busy     <= 1'b0;
            SPI_TX   <= 1'b0;
            SPI_CLK  <= 1'b0;
            SPI_CS   <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        state    <= SETUP;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        shreg    <= {1'b0, ordered_c[DATA_WIDTH-1:1]};
                        SPI_TX   <= ordered_c[0];
                        SPI_CS   <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SETUP: begin
                    if (phase_end_c) begin
                        cnt     <= '0;
                        state   <= HIGH;
                        SPI_CLK <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (phase_end_c) begin
                        cnt     <= '0;
                        SPI_CLK <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= HOLD;
                        end else begin
                            state   <= LOW;
                            SPI_TX  <= shreg[0];
                            shreg   <= {1'b0, shreg[DATA_WIDTH-1:1]};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (phase_end_c) begin
                        cnt     <= '0;
                        state   <= HIGH;
                        SPI_CLK <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (phase_end_c) begin
                        cnt     <= '0;
                        state   <= GAP;
                        SPI_CS  <= 1'b1;
                        SPI_TX  <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
